// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and the MULT/DIV sequencer state encoding.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_NOR  = 4'd6,
        ALU_SLT  = 4'd7,
        ALU_SLTU = 4'd8,
        ALU_SLL  = 4'd9,
        ALU_SRL  = 4'd10,
        ALU_SRA  = 4'd11,
        ALU_MULT = 4'd12,
        ALU_DIV  = 4'd13
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign application: MULT negates the full 2W-bit product as one value,
// otherwise hi and lo are negated independently (also used for operand abs() on entry).
module muldiv_sign_fix #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_mult,
    input  logic             neg_lo,
    input  logic             neg_hi,
    input  logic [WIDTH-1:0] mag_hi,
    input  logic [WIDTH-1:0] mag_lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [2*WIDTH-1:0] prod;

    always_comb begin
        prod   = {mag_hi, mag_lo};
        res_hi = mag_hi;
        res_lo = mag_lo;
        if (is_mult) begin
            if (neg_lo) begin
                prod = -prod;
            end
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else begin
            if (neg_lo) begin
                res_lo = -mag_lo;
            end
            if (neg_hi) begin
                res_hi = -mag_hi;
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed MULT (shift-add) / DIV (restoring) sequencer writing HI/LO.
// Optional MULDIV_EARLY_EXIT_EN: MULT stops once the remaining multiplier bits are zero.
module muldiv_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    muldiv_state_t      state;
    logic [CW-1:0]      count;
    logic               is_mult;
    logic               neg_q;
    logic               neg_r;
    // MULT: acc = product, opnd_a = shifted multiplicand, opnd_b = multiplier.
    // DIV:  acc = remainder, opnd_a = divisor, opnd_b = dividend shifting into quotient.
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0]   opnd_b;

    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] a_nxt;
    logic [WIDTH-1:0]   b_nxt;
    logic [WIDTH:0]     rem_sh;
    logic               rem_ge;
    logic               last;
    logic [2*WIDTH-1:0] src_acc;
    logic [WIDTH-1:0]   src_b;
    logic [WIDTH-1:0]   mag_hi;
    logic [WIDTH-1:0]   mag_lo;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    logic is_mult_op;
    logic is_div_op;
    assign is_mult_op = (alu_op == ALU_MULT);
    assign is_div_op  = (alu_op == ALU_DIV);

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_abs (
        .is_mult (1'b0),
        .neg_lo  (op_a[WIDTH-1]),
        .neg_hi  (op_b[WIDTH-1]),
        .mag_hi  (op_b),
        .mag_lo  (op_a),
        .res_hi  (abs_b),
        .res_lo  (abs_a)
    );

    always_comb begin
        acc_nxt = acc;
        a_nxt   = opnd_a;
        b_nxt   = opnd_b;
        rem_sh  = {acc[WIDTH-1:0], opnd_b[WIDTH-1]};
        rem_ge  = (rem_sh >= {1'b0, opnd_a[WIDTH-1:0]});
        if (is_mult) begin
            if (opnd_b[0]) begin
                acc_nxt = acc + opnd_a;
            end
            a_nxt = opnd_a << 1;
            b_nxt = opnd_b >> 1;
        end else if (rem_ge) begin
            acc_nxt = {{WIDTH{1'b0}}, rem_sh[WIDTH-1:0] - opnd_a[WIDTH-1:0]};
            b_nxt   = {opnd_b[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt = {{WIDTH{1'b0}}, rem_sh[WIDTH-1:0]};
            b_nxt   = {opnd_b[WIDTH-2:0], 1'b0};
        end
`ifdef MULDIV_EARLY_EXIT_EN
        last = (count == CW'(1)) || (is_mult && (b_nxt == '0));
`else
        last = (count == CW'(1));
`endif
    end

    // Final iteration feeds the fixup directly so hi/lo land on the same edge as DONE.
    always_comb begin
        src_acc = (state == BUSY) ? acc_nxt : acc;
        src_b   = (state == BUSY) ? b_nxt : opnd_b;
        mag_hi  = is_mult ? src_acc[2*WIDTH-1:WIDTH] : src_acc[WIDTH-1:0];
        mag_lo  = is_mult ? src_acc[WIDTH-1:0] : src_b;
    end

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_fix (
        .is_mult (is_mult),
        .neg_lo  (neg_q),
        .neg_hi  (neg_r),
        .mag_hi  (mag_hi),
        .mag_lo  (mag_lo),
        .res_hi  (fix_hi),
        .res_lo  (fix_lo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            is_mult <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            acc     <= '0;
            opnd_a  <= '0;
            opnd_b  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !flush && (is_mult_op || is_div_op)) begin
                        is_mult <= is_mult_op;
                        if (is_div_op && (op_b == '0)) begin
                            // Divide by zero: DONE with done low; hi/lo are written from here next edge.
                            acc    <= {{WIDTH{1'b0}}, op_a};
                            opnd_b <= '1;
                            neg_q  <= 1'b0;
                            neg_r  <= 1'b0;
                            count  <= '0;
                            state  <= DONE;
                        end else begin
                            acc    <= '0;
                            opnd_a <= {{WIDTH{1'b0}}, is_mult_op ? abs_a : abs_b};
                            opnd_b <= is_mult_op ? abs_b : abs_a;
                            neg_q  <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                            neg_r  <= is_div_op & op_a[WIDTH-1];
                            count  <= CW'(WIDTH);
                            busy   <= 1'b1;
                            state  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        count <= '0;
                        state <= IDLE;
                    end else begin
                        acc    <= acc_nxt;
                        opnd_a <= a_nxt;
                        opnd_b <= b_nxt;
                        count  <= count - CW'(1);
                        if (last) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            hi    <= fix_hi;
                            lo    <= fix_lo;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!done) begin
                        hi   <= fix_hi;
                        lo   <= fix_lo;
                        done <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer; latency expectations follow MULDIV_EARLY_EXIT_EN.
module tb_muldiv_sequencer;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks;
    int errors;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .alu_op (alu_op),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

`ifdef MULDIV_EARLY_EXIT_EN
    localparam int MUL73_DONE = 3;
    localparam int MUL73_BUSY = 2;
    localparam int MUL53_DONE = 3;
`else
    localparam int MUL73_DONE = 33;
    localparam int MUL73_BUSY = 32;
    localparam int MUL53_DONE = 33;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts an op at edge 0, then samples each cycle (negedge) for up to 40 cycles.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inj_cyc, input int flush_cyc, input bit flush0,
                          output int done_cyc, output int busy_cnt, output int last_busy,
                          output logic done_after);
        done_cyc   = -1;
        busy_cnt   = 0;
        last_busy  = 0;
        done_after = 1'b1;
        @(negedge clk);
        start  = 1'b1;
        alu_op = op;
        op_a   = a;
        op_b   = b;
        flush  = flush0;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                done_after = done;
                break;
            end
            if (busy) begin
                busy_cnt++;
                last_busy = c;
            end
            if (done && done_cyc < 0) done_cyc = c;
            if (c == inj_cyc) begin
                start  = 1'b1;
                alu_op = ALU_MULT;
                op_a   = 32'd2;
                op_b   = 32'd2;
            end else begin
                start = 1'b0;
            end
            flush = (c == flush_cyc);
        end
        start = 1'b0;
        flush = 1'b0;
    endtask

    int   dc;
    int   bc;
    int   lb;
    logic da;

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        start  = 1'b0;
        alu_op = ALU_NOP;
        op_a   = '0;
        op_b   = '0;
        flush  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        rst = 1'b0;

        run_op(ALU_MULT, 32'd7, 32'hFFFFFFFD, 0, 0, 0, dc, bc, lb, da);
        check("mul7x-3_done_cyc", dc, MUL73_DONE);
        check("mul7x-3_busy_cnt", bc, MUL73_BUSY);
        check("mul7x-3_last_busy", lb, MUL73_BUSY);
        check("mul7x-3_pulse", da, 0);
        check("mul7x-3_hi", hi, 32'hFFFFFFFF);
        check("mul7x-3_lo", lo, 32'hFFFFFFEB);

        run_op(ALU_MULT, 32'd5, 32'd3, 0, 0, 0, dc, bc, lb, da);
        check("mul5x3_done_cyc", dc, MUL53_DONE);
        check("mul5x3_hi", hi, 0);
        check("mul5x3_lo", lo, 15);

        run_op(ALU_MULT, 32'hFFFF0000, 32'hFFFF0000, 0, 0, 0, dc, bc, lb, da);
        check("mul_negneg_hi", hi, 32'h00000001);
        check("mul_negneg_lo", lo, 32'h00000000);

        run_op(ALU_MULT, 32'h80000000, 32'h80000000, 0, 0, 0, dc, bc, lb, da);
        check("mul_minmin_done_cyc", dc, 33);
        check("mul_minmin_hi", hi, 32'h40000000);
        check("mul_minmin_lo", lo, 32'h00000000);

        run_op(ALU_DIV, 32'hFFFFFFF9, 32'd2, 0, 0, 0, dc, bc, lb, da);
        check("div-7/2_done_cyc", dc, 33);
        check("div-7/2_busy_cnt", bc, 32);
        check("div-7/2_lo", lo, 32'hFFFFFFFD);
        check("div-7/2_hi", hi, 32'hFFFFFFFF);

        run_op(ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, dc, bc, lb, da);
        check("divmin/-1_lo", lo, 32'h80000000);
        check("divmin/-1_hi", hi, 32'h00000000);

        run_op(ALU_DIV, 32'd9, 32'd0, 0, 0, 0, dc, bc, lb, da);
        check("div9/0_done_cyc", dc, 2);
        check("div9/0_busy_cnt", bc, 0);
        check("div9/0_pulse", da, 0);
        check("div9/0_hi", hi, 9);
        check("div9/0_lo", lo, 32'hFFFFFFFF);

        run_op(ALU_DIV, 32'd100, 32'd7, 5, 0, 0, dc, bc, lb, da);
        check("div_inj_done_cyc", dc, 33);
        check("div_inj_lo", lo, 14);
        check("div_inj_hi", hi, 2);
        check("div_inj_idle_after", busy, 0);

        run_op(ALU_ADD, 32'd1, 32'd1, 0, 0, 0, dc, bc, lb, da);
        check("add_busy_cnt", bc, 0);
        check("add_no_done", dc, -1);

        run_op(ALU_MULT, 32'd6, 32'h40000000, 0, 10, 0, dc, bc, lb, da);
        check("flush_last_busy", lb, 10);
        check("flush_busy_cnt", bc, 10);
        check("flush_no_done", dc, -1);
        check("flush_hi_kept", hi, 2);
        check("flush_lo_kept", lo, 14);

        run_op(ALU_MULT, 32'd6, 32'd6, 0, 0, 1, dc, bc, lb, da);
        check("idle_flush_start_busy", bc, 0);
        check("idle_flush_start_done", dc, -1);

        @(negedge clk);
        start  = 1'b1;
        alu_op = ALU_MULT;
        op_a   = 32'd7;
        op_b   = 32'h40000000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_hi", hi, 0);
        check("rst_mid_lo", lo, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
